// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MiniMIPS multi-cycle divider.
// Holds the divider state encoding, the iteration count, the quotient
// reported for a zero divisor, and a small absolute-value helper used
// when signed operands are captured.
package mips_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  localparam int          DIV_ITER   = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF;

  // Magnitude of a 32-bit operand. 0x80000000 maps onto itself, which is
  // the correct unsigned magnitude, so the overflow case needs no special path.
  function automatic logic [31:0] abs32(input logic [31:0] value, input logic is_sgn);
    return (is_sgn && value[31]) ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/adder_32bit.sv
// adder_32bit: plain 32-bit ripple adder with carry in and carry out.
// The divider reuses it both as the trial subtractor (b inverted,
// carry_in=1) and as a two's-complement negator (a inverted, b=0, carry_in=1).
// Ports:
//   a, b       32-bit addends
//   carry_in   carry into bit 0
//   sum        32-bit result
//   carry_out  carry out of bit 31 (no-borrow flag when subtracting)
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        carry_out
);

  logic [32:0] full;

  assign full      = {1'b0, a} + {1'b0, b} + {32'd0, carry_in};
  assign sum       = full[31:0];
  assign carry_out = full[32];

endmodule

// File: rtl/mips_divider_32bit.sv
// mips_divider_32bit: multi-cycle shift-and-subtract divider for DIV/DIVU.
// Quotient goes to lo, remainder to hi. Operands are captured on an
// accepted start, 32 restoring iterations run one per cycle, one FIX
// cycle applies the sign correction, then done pulses for one cycle.
// Optional build macro MIPS_DIV_ZERO_DETECT_EN adds div_by_zero and an
// early exit for a zero divisor.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start, is_signed    request pulse (IDLE only) and DIV/DIVU select
//   dividend, divisor   operands, captured on accepted start
//   busy, done          in-progress flag and one-cycle completion pulse
//   lo, hi              quotient and remainder, held until the next FIX
//   div_by_zero         (macro only) zero-divisor flag
module mips_divider_32bit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
`ifdef MIPS_DIV_ZERO_DETECT_EN
  ,
  output logic             div_by_zero
`endif
);

  div_state_t       state, next_state;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             q_neg, r_neg;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] neg_sum;
  logic             neg_carry_unused;

  logic [WIDTH-1:0] rem_shift;
  logic             no_borrow;

`ifdef MIPS_DIV_ZERO_DETECT_EN
  // Holds DONE for one extra busy cycle so the zero-divisor exit reports
  // done two cycles after the start edge.
  logic             dz_wait;
`endif

  // Trial subtract in CALC; negates the quotient in FIX.
  adder_32bit u_trial (
    .a         (add_a),
    .b         (add_b),
    .carry_in  (1'b1),
    .sum       (add_sum),
    .carry_out (add_cout)
  );

  // Dedicated negator for the remainder sign fix.
  adder_32bit u_neg (
    .a         (~rem),
    .b         ('0),
    .carry_in  (1'b1),
    .sum       (neg_sum),
    .carry_out (neg_carry_unused)
  );

  assign rem_shift = {rem[WIDTH-2:0], quo[WIDTH-1]};
  // The shifted remainder is really 33 bits; a set top bit guarantees it
  // exceeds the divisor, so there is no borrow regardless of carry_out.
  assign no_borrow = rem[WIDTH-1] | add_cout;

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    add_a      = rem_shift;
    add_b      = ~dvs;
    case (state)
      DIV_IDLE: begin
        if (start) begin
          next_state = DIV_CALC;
`ifdef MIPS_DIV_ZERO_DETECT_EN
          if (divisor == '0) next_state = DIV_DONE;
`endif
        end
      end
      DIV_CALC: begin
        busy = 1'b1;
        if (count == CNT_W'(DIV_ITER - 1)) next_state = DIV_FIX;
      end
      DIV_FIX: begin
        busy       = 1'b1;
        add_a      = ~quo;
        add_b      = '0;
        next_state = DIV_DONE;
      end
      DIV_DONE: begin
`ifdef MIPS_DIV_ZERO_DETECT_EN
        if (dz_wait) begin
          busy = 1'b1;
        end else begin
          done       = 1'b1;
          next_state = DIV_IDLE;
        end
`else
        done       = 1'b1;
        next_state = DIV_IDLE;
`endif
      end
      default: next_state = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DIV_IDLE;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      count <= '0;
      lo    <= '0;
      hi    <= '0;
`ifdef MIPS_DIV_ZERO_DETECT_EN
      div_by_zero <= 1'b0;
      dz_wait     <= 1'b0;
`endif
    end else begin
      state <= next_state;
      case (state)
        DIV_IDLE: begin
          if (start) begin
            rem   <= '0;
            quo   <= abs32(dividend, is_signed);
            dvs   <= abs32(divisor, is_signed);
            q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= is_signed & dividend[WIDTH-1];
            count <= '0;
`ifdef MIPS_DIV_ZERO_DETECT_EN
            div_by_zero <= 1'b0;
            dz_wait     <= 1'b0;
            if (divisor == '0) begin
              div_by_zero <= 1'b1;
              dz_wait     <= 1'b1;
              lo          <= DIV_ZERO_Q;
              hi          <= dividend;
            end
`endif
          end
        end
        DIV_CALC: begin
          count <= count + CNT_W'(1);
          quo   <= {quo[WIDTH-2:0], no_borrow};
          rem   <= no_borrow ? add_sum : rem_shift;
        end
        DIV_FIX: begin
          lo <= q_neg ? add_sum : quo;
          hi <= r_neg ? neg_sum : rem;
        end
        DIV_DONE: begin
`ifdef MIPS_DIV_ZERO_DETECT_EN
          dz_wait <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mips_divider_32bit.md
Name: mips_divider_32bit

Overview:
- Multi-cycle 32-bit integer divider for the MiniMIPS execute stage. Implements DIV and DIVU: quotient to LO, remainder to HI.
- Works by repeated shift-and-subtract, the inverse of the 32-bit adder path.
- Sits beside the ALU. The control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is supported.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU
- dividend  input  32  numerator; captured when start is accepted
- divisor  input  32  denominator; captured when start is accepted
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results are valid
- lo  output  32  quotient
- hi  output  32  remainder
- div_by_zero  output  1  only present with the optional feature

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: busy=0, done=0, lo=0, hi=0, div_by_zero=0, state=IDLE, counter=0.
- States and transitions:
  - IDLE -> CALC on start=1. Capture operands. In signed mode, take absolute values and record q_neg = dividend[31]^divisor[31] and r_neg = dividend[31]. In unsigned mode, q_neg = r_neg = 0.
  - CALC: 32 iterations, one per cycle. Each iteration:
    - Shift {rem, quo} left by 1.
    - Compute trial = rem - |divisor| as a 33-bit subtraction (rem + ~div + 1).
    - If there is no borrow, rem = trial and quo[0] = 1; otherwise quo[0] = 0.
    - The counter increments each iteration; after iteration 32 -> FIX.
  - FIX: one cycle. lo = q_neg ? -quo : quo; hi = r_neg ? -rem : rem. -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- Latency: start sampled at edge N. busy=1 from N+1 through N+33. done=1 during N+34 with lo/hi valid.
- lo/hi hold their values until the next operation's FIX cycle. They are not cleared by start.
- start while busy (CALC/FIX/DONE) is ignored, and the operands are not recaptured.
- Operand inputs may change freely after the capture edge.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap is raised; the result falls out of the algorithm naturally.
- Divide by zero without the feature: runs the full 32 iterations. Unsigned gives lo=0xFFFFFFFF, hi=dividend. Signed gives the sign fix applied to those magnitudes.
- Reset asserted mid-operation: the next edge forces IDLE and zeroes all outputs. Any in-flight result is discarded.
- Reset and start in the same cycle: reset wins; the start is dropped.

Optional Feature:
- Macro: MIPS_DIV_ZERO_DETECT_EN.
- Defined:
  - Adds the div_by_zero output port.
  - At capture, if divisor==0, go IDLE -> DONE directly, skipping CALC and FIX.
  - Outputs: lo=0xFFFFFFFF, hi=dividend unmodified, div_by_zero=1. done rises at N+2 and busy is high only at N+1.
  - div_by_zero clears at the next accepted start.
- Undefined: no port, no early exit; divide by zero behaves as described in Behaviour.

Decomposition:
- Shared package mips_pkg holds:
  - state encoding: DIV_IDLE=2'd0, DIV_CALC=2'd1, DIV_FIX=2'd2, DIV_DONE=2'd3
  - DIV_ITER=32
  - DIV_ZERO_Q=32'hFFFFFFFF
- One natural sub-module: the existing adder_32bit, used as the trial subtractor (inverted divisor, carry_in=1). Its carry_out indicates no borrow.
- Negation in FIX uses a second adder_32bit instance or a shared mux onto the same instance.
- FSM and shift registers stay in the top module.

Test Plan:
- Unsigned: dividend=100, divisor=7, is_signed=0 -> done at start+34, lo=14, hi=2, busy high for exactly 33 cycles.
- Signed: dividend=-7 (0xFFFFFFF9), divisor=2, is_signed=1 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also 7/-2 -> lo=-3, hi=1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Unsigned 0xFFFFFFFF / 1 -> lo=0xFFFFFFFF, hi=0.
- Divide by zero, dividend=0x12345678, divisor=0, unsigned:
  - without macro -> done at +34, lo=0xFFFFFFFF, hi=0x12345678;
  - with macro -> done at +2, div_by_zero=1, same lo/hi.
- Start during busy: start 100/7, then pulse start with 50/5 at +10 -> still one done at +34 with lo=14, hi=2, and no second done.
- Reset mid-operation: start 100/7, assert reset at +15 for 1 cycle -> next cycle busy=0, done=0, lo=hi=0. A following start of 9/3 -> lo=3, hi=0 at +34.
